int_to_float_pipe: RTL and testbench

- Parametrised, pipelined integer to IEEE-754 single-precision converter.
- Accepts signed or unsigned integers up to 32 bits.
- Rounds to nearest-even when the magnitude exceeds 24 significant bits, and flags inexact results.
- Sits between integer datapaths and the float units; uses a valid/ready handshake on both sides with a throughput of one conversion per cycle.

---
 rtl/int_to_float_pipe.sv | 117 +++++++++++
 tb/tb_int_to_float_pipe.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/int_to_float_pipe.sv
// Integer (signed/unsigned, up to 32 bits) to IEEE-754 single converter, round-to-nearest-even, 2-cycle latency.
// Valid/ready on both sides, one result per cycle; a stalled output holds both stages and drops in_ready.
module int_to_float_pipe #(
    parameter int IN_W   = 16,
    parameter bit SIGNED = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [31:0]     out_data,
    output logic            out_inexact,
    output logic            out_valid,
    input  logic            out_ready
);

    typedef struct packed {
        logic            sign;
        logic [IN_W-1:0] mag;
    } s1_t;

    typedef struct packed {
        logic [31:0] data;
        logic        inexact;
    } s2_t;

    logic        r_v1;
    logic        r_v2;
    s1_t         r_s1;
    s2_t         r_s2;

    logic        w_adv1;
    logic        w_adv2;
    logic        w_neg;
    s1_t         w_s1_nxt;
    logic [31:0] w_mag32;
    logic [4:0]  w_msb;
    logic [4:0]  w_shamt;
    logic [31:0] w_norm;
    logic [22:0] w_frac;
    logic        w_guard;
    logic        w_sticky;
    logic        w_rnd;
    logic [23:0] w_frac_rnd;
    logic [7:0]  w_exp;
    s2_t         w_s2_nxt;

    assign w_adv2   = !r_v2 || out_ready;
    assign w_adv1   = !r_v1 || w_adv2;
    assign in_ready = w_adv1;

    // IN_W-bit unsigned magnitude: the most negative input maps to 2^(IN_W-1) without overflow.
    assign w_neg = SIGNED & in_data[IN_W-1];

    always_comb begin
        w_s1_nxt      = '0;
        w_s1_nxt.sign = w_neg;
        w_s1_nxt.mag  = w_neg ? ((~in_data) + IN_W'(1)) : in_data;
    end

    assign w_mag32 = 32'(r_s1.mag);

    always_comb begin
        w_msb = '0;
        for (int i = 0; i < 32; i++) begin
            if (w_mag32[i]) begin
                w_msb = 5'(i);
            end
        end
    end

    // Leading one lands on bit 31; fraction, guard and sticky then sit at fixed positions.
    assign w_shamt    = 5'd31 - w_msb;
    assign w_norm     = w_mag32 << w_shamt;
    assign w_frac     = w_norm[30:8];
    assign w_guard    = w_norm[7];
    assign w_sticky   = |w_norm[6:0];
    assign w_rnd      = w_guard & (w_sticky | w_frac[0]);
    assign w_frac_rnd = {1'b0, w_frac} + {23'd0, w_rnd};
    assign w_exp      = 8'd127 + {3'd0, w_msb} + {7'd0, w_frac_rnd[23]};

    always_comb begin
        w_s2_nxt = '0;
        if (w_norm[31]) begin
            w_s2_nxt.data    = {r_s1.sign, w_exp, w_frac_rnd[22:0]};
            w_s2_nxt.inexact = w_guard | w_sticky;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            if (w_adv1) begin
                r_v1 <= in_valid;
            end
            if (w_adv1 && in_valid) begin
                r_s1 <= w_s1_nxt;
            end
            if (w_adv2) begin
                r_v2 <= r_v1;
            end
            if (w_adv2 && r_v1) begin
                r_s2 <= w_s2_nxt;
            end
        end
    end

    assign out_valid   = r_v2;
    assign out_data    = r_s2.data;
    assign out_inexact = r_s2.inexact;

endmodule

// File: tb/tb_int_to_float_pipe.sv
// Bench for int_to_float_pipe: four configurations share one stimulus bus; a scoreboard queue
// holds expected results and a monitor pops and compares them as the selected instance emits.
module tb_int_to_float_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        out_ready;
    logic [31:0] drv_data;
    logic [3:0]  vld;
    logic [3:0]  rdy;
    logic [3:0]  ov;
    logic [3:0]  oi;
    logic [31:0] o_dat [4];

    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    typedef struct {
        int          id;
        logic [31:0] d;
        logic        x;
    } exp_t;

    exp_t sb[$];
    int   out_edges[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int_to_float_pipe #(.IN_W(16), .SIGNED(1'b1)) u_s16 (
        .clk(clk), .rst(rst), .in_data(drv_data[15:0]), .in_valid(vld[0]), .in_ready(rdy[0]),
        .out_data(o_dat[0]), .out_inexact(oi[0]), .out_valid(ov[0]), .out_ready(out_ready));
    int_to_float_pipe #(.IN_W(8), .SIGNED(1'b0)) u_u8 (
        .clk(clk), .rst(rst), .in_data(drv_data[7:0]), .in_valid(vld[1]), .in_ready(rdy[1]),
        .out_data(o_dat[1]), .out_inexact(oi[1]), .out_valid(ov[1]), .out_ready(out_ready));
    int_to_float_pipe #(.IN_W(32), .SIGNED(1'b0)) u_u32 (
        .clk(clk), .rst(rst), .in_data(drv_data), .in_valid(vld[2]), .in_ready(rdy[2]),
        .out_data(o_dat[2]), .out_inexact(oi[2]), .out_valid(ov[2]), .out_ready(out_ready));
    int_to_float_pipe #(.IN_W(32), .SIGNED(1'b1)) u_s32 (
        .clk(clk), .rst(rst), .in_data(drv_data), .in_valid(vld[3]), .in_ready(rdy[3]),
        .out_data(o_dat[3]), .out_inexact(oi[3]), .out_valid(ov[3]), .out_ready(out_ready));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Outputs are consumed on the edge after this negedge; record that edge index.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_ready) begin
            for (int k = 0; k < 4; k++) begin
                if (ov[k]) begin
                    check($sformatf("sb_nonempty%0d", k), 64'(sb.size() > 0), 64'(1));
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check($sformatf("out_id%0d", k), k, e.id);
                        check($sformatf("out_dat%0d", k), {o_dat[k], oi[k]}, {e.d, e.x});
                        out_edges.push_back(cyc + 1);
                    end
                end
            end
        end
    end

    task automatic send(input int id, input logic [31:0] val, input logic [31:0] ed,
                        input logic ex, output int acc);
        int   n;
        exp_t e;
        drv_data = val;
        vld      = 4'b0000;
        vld[id]  = 1'b1;
        n        = 0;
        @(negedge clk);
        while (!rdy[id] && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("accept", rdy[id], 1'b1);
        e.id = id;
        e.d  = ed;
        e.x  = ex;
        sb.push_back(e);
        @(posedge clk);
        #1;
        vld = 4'b0000;
        acc = cyc;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check(tag, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          acc0;
        int          acc;
        int          a;
        int          bp_acc;
        logic [31:0] held;
        logic [31:0] bp_exp [5];

        bp_exp[0] = 32'h3F800000;
        bp_exp[1] = 32'h40000000;
        bp_exp[2] = 32'h40400000;
        bp_exp[3] = 32'h40800000;
        bp_exp[4] = 32'h40A00000;

        rst       = 1'b1;
        out_ready = 1'b1;
        vld       = 4'b0000;
        drv_data  = '0;
        #12;
        check("rst_out_valid", ov, 4'b0000);
        check("rst_out_inexact", oi, 4'b0000);
        check("rst_out_data0", o_dat[0], 32'h0);
        check("rst_out_data3", o_dat[3], 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rdy_after_rst", rdy, 4'hF);
        @(posedge clk);
        #1;

        // Back-to-back signed 16-bit: results on consecutive edges, first two edges after accept.
        out_edges.delete();
        send(0, 32'h0001, 32'h3F800000, 1'b0, acc0);
        send(0, 32'hFFFF, 32'hBF800000, 1'b0, a);
        send(0, 32'h0000, 32'h00000000, 1'b0, a);
        send(0, 32'h8000, 32'hC7000000, 1'b0, a);
        drain("t1_drain");
        check("t1_count", out_edges.size(), 4);
        for (int i = 0; i < 4 && i < out_edges.size(); i++) begin
            check($sformatf("t1_edge%0d", i), out_edges[i], acc0 + 2 + i);
        end

        send(0, 32'h7FFF, 32'h46FFFE00, 1'b0, a);
        send(0, 32'hFFFB, 32'hC0A00000, 1'b0, a);
        drain("s16_drain");

        send(1, 32'hFF, 32'h437F0000, 1'b0, a);
        send(1, 32'h80, 32'h43000000, 1'b0, a);
        drain("u8_drain");

        send(2, 32'd16777217, 32'h4B800000, 1'b1, a);
        send(2, 32'd16777219, 32'h4B800002, 1'b1, a);
        send(2, 32'hFFFFFFFF, 32'h4F800000, 1'b1, a);
        send(2, 32'd16777216, 32'h4B800000, 1'b0, a);
        drain("u32_drain");

        send(3, 32'h80000000, 32'hCF000000, 1'b0, a);
        send(3, 32'h7FFFFFFF, 32'h4F000000, 1'b1, a);
        send(3, 32'hFFFFFFFF, 32'hBF800000, 1'b0, a);
        drain("s32_drain");

        // Back-pressure: consumer stalls for four edges while five operands are offered.
        out_ready = 1'b0;
        bp_acc    = 0;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    send(0, 32'(i + 1), bp_exp[i], 1'b0, a);
                    bp_acc++;
                end
            end
            begin
                repeat (3) @(negedge clk);
                held = o_dat[0];
                check("bp_out_valid", ov[0], 1'b1);
                @(negedge clk);
                check("bp_in_ready", rdy[0], 1'b0);
                check("bp_accepts", bp_acc, 2);
                check("bp_stable", o_dat[0], held);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("bp_drain");

        // Asynchronous reset with both stages full: flushed operands never appear.
        out_ready = 1'b0;
        send(0, 32'h7, 32'h40E00000, 1'b0, a);
        send(0, 32'h9, 32'h41100000, 1'b0, a);
        check("rst_pre_valid", ov[0], 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_valid", ov[0], 1'b0);
        check("rst_mid_data", o_dat[0], 32'h0);
        sb.delete();
        out_edges.delete();
        out_ready = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("flush_no_out", ov[0], 1'b0);
        @(posedge clk);
        #1;
        send(0, 32'h3, 32'h40400000, 1'b0, acc);
        drain("rst_drain");
        check("rst_count", out_edges.size(), 1);
        if (out_edges.size() > 0) begin
            check("rst_edge", out_edges[0], acc + 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
